// File: rtl/l1_dcache_assoc.sv
// rtl/l1_dcache_assoc.sv - set-associative write-back, write-allocate L1 data cache with age-based LRU
// Define L1_DCACHE_STATS_EN to add the hit_count/miss_count outputs.
module l1_dcache_assoc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef L1_DCACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - IDX_W - WRD_W - OFF_W;
  localparam logic [WRD_W-1:0] BEAT_LAST = WRD_W'(LINE_WORDS - 1);
  localparam logic [AGE_W-1:0] AGE_MAX   = AGE_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

  state_t            r_state, w_state_next;
  logic              r_valid [SETS][WAYS];
  logic              r_dirty [SETS][WAYS];
  logic [AGE_W-1:0]  r_age   [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [DATA_W-1:0] r_data  [SETS][WAYS][LINE_WORDS];

  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [AGE_W-1:0]  r_way;
  logic [WRD_W-1:0]  r_beat, r_fill;
  logic              r_req_done, r_resp_valid;
  logic [DATA_W-1:0] r_rdata;

  logic [TAG_W-1:0]  w_in_tag, w_r_tag;
  logic [IDX_W-1:0]  w_in_idx, w_r_idx;
  logic [WRD_W-1:0]  w_in_word, w_r_word;
  logic              w_hit, w_has_inv, w_accept, w_mem_fire, w_resp_fire, w_fill_last, w_hit_done;
  logic [AGE_W-1:0]  w_hit_way, w_victim;
  logic              w_age_en;
  logic [IDX_W-1:0]  w_age_set;
  logic [AGE_W-1:0]  w_age_way, w_age_prev;
  logic              w_unused;

  assign w_in_tag  = cpu_req_addr[ADDR_W-1 -: TAG_W];
  assign w_in_idx  = cpu_req_addr[OFF_W+WRD_W +: IDX_W];
  assign w_in_word = cpu_req_addr[OFF_W +: WRD_W];
  assign w_r_tag   = r_addr[ADDR_W-1 -: TAG_W];
  assign w_r_idx   = r_addr[OFF_W+WRD_W +: IDX_W];
  assign w_r_word  = r_addr[OFF_W +: WRD_W];
  assign w_unused  = ^{cpu_req_addr[OFF_W-1:0], r_addr[OFF_W-1:0]};

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_in_idx][w] && r_tag[w_in_idx][w] == w_in_tag) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
      if (!r_valid[w_in_idx][w] && !w_has_inv) begin
        w_has_inv = 1'b1;
        w_victim  = AGE_W'(w);
      end
    end
    if (!w_has_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w_in_idx][w] == AGE_MAX) w_victim = AGE_W'(w);
      end
    end
  end

  assign w_accept    = cpu_req_valid && cpu_req_ready;
  assign w_mem_fire  = mem_req_valid && mem_req_ready;
  assign w_resp_fire = mem_resp_valid && (r_state == REFILL);
  assign w_fill_last = w_resp_fire && (r_fill == BEAT_LAST);
  assign w_hit_done  = (r_state == IDLE) && w_accept && w_hit;

  // A refilled way is treated as previously oldest so every other way ages,
  // keeping ages a permutation once the set is full.
  assign w_age_en   = w_hit_done || (r_state == RESPOND);
  assign w_age_set  = (r_state == IDLE) ? w_in_idx : w_r_idx;
  assign w_age_way  = (r_state == IDLE) ? w_hit_way : r_way;
  assign w_age_prev = (r_state == IDLE) ? r_age[w_in_idx][w_hit_way] : AGE_MAX;

  always_comb begin
    w_state_next  = r_state;
    cpu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (r_state)
      IDLE: begin
        cpu_req_ready = !reset;
        if (w_accept && !w_hit)
          w_state_next = (r_valid[w_in_idx][w_victim] && r_dirty[w_in_idx][w_victim]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_req_valid = !reset;
        mem_req_we    = !reset;
        mem_req_addr  = {r_tag[w_r_idx][r_way], w_r_idx, r_beat, {OFF_W{1'b0}}};
        mem_req_wdata = r_data[w_r_idx][r_way][r_beat];
        if (w_mem_fire && r_beat == BEAT_LAST) w_state_next = REFILL;
      end
      REFILL: begin
        mem_req_valid = !r_req_done && !reset;
        mem_req_addr  = {w_r_tag, w_r_idx, r_beat, {OFF_W{1'b0}}};
        if (w_fill_last) w_state_next = RESPOND;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_fill       <= '0;
      r_req_done   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= '0;
        end
      end
    end else begin
      r_state      <= w_state_next;
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_addr  <= cpu_req_addr;
          r_we    <= cpu_req_we;
          r_wdata <= cpu_req_wdata;
          if (w_hit) begin
            r_resp_valid <= 1'b1;
            r_rdata      <= cpu_req_we ? '0 : r_data[w_in_idx][w_hit_way][w_in_word];
            if (cpu_req_we) r_dirty[w_in_idx][w_hit_way] <= 1'b1;
          end else begin
            r_way      <= w_victim;
            r_beat     <= '0;
            r_fill     <= '0;
            r_req_done <= 1'b0;
          end
        end
        WRITEBACK: if (w_mem_fire) r_beat <= r_beat + WRD_W'(1);
        REFILL: begin
          if (w_mem_fire) begin
            r_beat <= r_beat + WRD_W'(1);
            if (r_beat == BEAT_LAST) r_req_done <= 1'b1;
          end
          if (w_resp_fire) r_fill <= r_fill + WRD_W'(1);
          if (w_fill_last) begin
            r_valid[w_r_idx][r_way] <= 1'b1;
            r_dirty[w_r_idx][r_way] <= 1'b0;
          end
        end
        default: begin
          r_resp_valid <= 1'b1;
          r_rdata      <= r_we ? '0 : r_data[w_r_idx][r_way][w_r_word];
          if (r_we) r_dirty[w_r_idx][r_way] <= 1'b1;
        end
      endcase
      // Ways younger than the accessed one age by one; bounded by w_age_prev so no overflow.
      if (w_age_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == w_age_way) r_age[w_age_set][w] <= '0;
          else if (r_age[w_age_set][w] < w_age_prev) r_age[w_age_set][w] <= r_age[w_age_set][w] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_hit_done && cpu_req_we) r_data[w_in_idx][w_hit_way][w_in_word] <= cpu_req_wdata;
      if (w_resp_fire) r_data[w_r_idx][r_way][r_fill] <= mem_resp_rdata;
      if (w_fill_last) r_tag[w_r_idx][r_way] <= w_r_tag;
      if (r_state == RESPOND && r_we) r_data[w_r_idx][r_way][w_r_word] <= r_wdata;
    end
  end

`ifdef L1_DCACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_done) r_hit_count <= r_hit_count + 32'd1;
      if (r_state == RESPOND) r_miss_count <= r_miss_count + 32'd1;
    end
  end
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

  assign cpu_resp_valid = r_resp_valid && !reset;
  assign cpu_resp_rdata = reset ? '0 : r_rdata;
endmodule

// File: tb/tb_l1_dcache_assoc.sv
// tb/tb_l1_dcache_assoc.sv - directed self-checking bench for l1_dcache_assoc with a simple in-order memory model
`timescale 1ns/1ps
module tb_l1_dcache_assoc;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr, cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
`ifdef L1_DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  l1_dcache_assoc dut (
    .clk(clk), .reset(reset),
`ifdef L1_DCACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  logic [31:0] wmem [logic [31:0]];
  logic [31:0] rq[$];
  logic        ev_we[$];
  logic [31:0] ev_addr[$];
  logic [31:0] ev_data[$];
  int          stall = 0;
  bit          bp_arm = 1'b0;

  function automatic logic [31:0] memread(input logic [31:0] a);
    return wmem.exists(a) ? wmem[a] : memval(a);
  endfunction

  // Memory: accepts a beat on a negedge-visible handshake, answers one cycle later in order.
  initial begin
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rq.size() > 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = memread(rq.pop_front());
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
      end
      if (stall > 0) begin
        mem_req_ready = 1'b0;
        stall--;
        if (mem_req_valid) begin
          check("bp_addr_hold", mem_req_addr, 32'h0000_1004);
          check("bp_wdata_hold", mem_req_wdata, 32'hDEAD_BEEF);
        end
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        ev_we.push_back(mem_req_we);
        ev_addr.push_back(mem_req_addr);
        ev_data.push_back(mem_req_wdata);
        if (mem_req_we) wmem[mem_req_addr] = mem_req_wdata;
        else rq.push_back(mem_req_addr);
        if (bp_arm && mem_req_we) begin
          bp_arm = 1'b0;
          stall  = 3;
        end
      end
    end
  end

  task automatic ev_clear();
    ev_we.delete();
    ev_addr.delete();
    ev_data.delete();
  endtask

  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat);
    int n;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    n = 0;
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", {31'b0, cpu_req_ready}, 32'd1);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    lat = 1;
    while (!cpu_resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("resp_seen", {31'b0, cpu_resp_valid}, 32'd1);
    rdata = cpu_resp_rdata;
  endtask

  task automatic check_reads(input string tag, input logic [31:0] base);
    check({tag, "_beats"}, ev_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < ev_addr.size(); i++) begin
      check({tag, "_rd_we"}, {31'b0, ev_we[i]}, 32'd0);
      check({tag, "_rd_addr"}, ev_addr[i], base + 32'(4 * i));
    end
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    reset = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, cpu_req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, cpu_resp_valid}, 32'd0);
    check("rst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_mem_we", {31'b0, mem_req_we}, 32'd0);
    check("rst_rdata", cpu_resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'b0, cpu_req_ready}, 32'd1);

    ev_clear();
    cpu_op(1'b0, 32'h1000, '0, rd, lat);
    check("cold_rdata", rd, 32'hA5A5_1000);
    check("cold_is_miss", 32'(lat > 1), 32'd1);
    check_reads("cold", 32'h1000);

    ev_clear();
    cpu_op(1'b0, 32'h1000, '0, rd, lat);
    check("rehit_rdata", rd, 32'hA5A5_1000);
    check("rehit_lat", lat, 32'd1);
    check("rehit_no_mem", ev_addr.size(), 32'd0);
`ifdef L1_DCACHE_STATS_EN
    check("stats_hit", hit_count, 32'd1);
    check("stats_miss", miss_count, 32'd1);
`endif

    cpu_op(1'b1, 32'h1004, 32'hDEAD_BEEF, rd, lat);
    check("st_lat", lat, 32'd1);
    check("st_rdata_zero", rd, 32'd0);
    cpu_op(1'b0, 32'h1004, '0, rd, lat);
    check("st_readback", rd, 32'hDEAD_BEEF);
    check("st_readback_lat", lat, 32'd1);

    cpu_op(1'b0, 32'h1400, '0, rd, lat);
    check("fill_1400", rd, 32'hA5A5_1400);
    cpu_op(1'b0, 32'h1808, '0, rd, lat);
    check("fill_1808", rd, 32'hA5A5_1808);
    cpu_op(1'b0, 32'h1C0C, '0, rd, lat);
    check("fill_1c0c", rd, 32'hA5A5_1C0C);

    ev_clear();
    bp_arm = 1'b1;
    cpu_op(1'b0, 32'h2000, '0, rd, lat);
    check("evict_rdata", rd, 32'hA5A5_2000);
    check("evict_events", ev_addr.size(), 32'd8);
    for (int i = 0; i < 4 && i < ev_addr.size(); i++) begin
      check("wb_we", {31'b0, ev_we[i]}, 32'd1);
      check("wb_addr", ev_addr[i], 32'h1000 + 32'(4 * i));
      check("wb_data", ev_data[i], (i == 1) ? 32'hDEAD_BEEF : memval(32'h1000 + 32'(4 * i)));
    end
    for (int i = 4; i < 8 && i < ev_addr.size(); i++) begin
      check("ev_rd_we", {31'b0, ev_we[i]}, 32'd0);
      check("ev_rd_addr", ev_addr[i], 32'h2000 + 32'(4 * (i - 4)));
    end

    cpu_op(1'b0, 32'h1404, '0, rd, lat);
    check("survivor_lat", lat, 32'd1);
    check("survivor_rdata", rd, 32'hA5A5_1404);
    ev_clear();
    cpu_op(1'b0, 32'h1004, '0, rd, lat);
    check("refetch_wb_data", rd, 32'hDEAD_BEEF);
    check_reads("refetch", 32'h1000);

    ev_clear();
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h3000;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    for (int n = 0; n < 50 && ev_addr.size() < 2; n++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    check("mid_beats", ev_addr.size(), 32'd2);
    @(negedge clk);
    check("mid_rst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, cpu_req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {31'b0, cpu_req_ready}, 32'd1);
    check("post_rst_no_beats", ev_addr.size(), 32'd2);
    ev_clear();
    cpu_op(1'b0, 32'h3008, '0, rd, lat);
    check("rst_refetch_rdata", rd, 32'hA5A5_3008);
    check("rst_refetch_miss", 32'(lat > 1), 32'd1);
    check_reads("rst_refetch", 32'h3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1_dcache_assoc.md
L1_DCACHE_ASSOC -- requirements
Module: l1_dcache_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width; 32 or 64 only.
REQ-003 SHALL have parameter SETS, default 64, set count; power of two, 2 or more.
REQ-004 SHALL have parameter WAYS, default 4, associativity; power of two, 2 or more.
REQ-005 SHALL have parameter LINE_WORDS, default 4, words per line; power of two.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port cpu_req_valid, input, 1 bit: CPU request present.
REQ-009 SHALL have port cpu_req_ready, output, 1 bit: cache accepts a request.
REQ-010 SHALL have port cpu_req_we, input, 1 bit: 1 = store, 0 = load.
REQ-011 SHALL have port cpu_req_addr, input, ADDR_W bits: byte address, word-aligned.
REQ-012 SHALL have port cpu_req_wdata, input, DATA_W bits: store data.
REQ-013 SHALL have port cpu_resp_valid, output, 1 bit: single-cycle completion pulse for loads and stores.
REQ-014 SHALL have port cpu_resp_rdata, output, DATA_W bits: load data; 0 for stores.
REQ-015 SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1), mem_req_we (output, 1), mem_req_addr (output, ADDR_W) and mem_req_wdata (output, DATA_W): next-level memory request per beat.
REQ-016 SHALL have ports mem_resp_valid (input, 1) and mem_resp_rdata (input, DATA_W): refill read data, returned in request order.

Function
REQ-017 SHALL split the address as tag | index (log2 SETS) | word (log2 LINE_WORDS) | byte offset (log2(DATA_W/8)).
REQ-018 SHALL store per way: valid, dirty, tag, LINE_WORDS data words, and a log2(WAYS)-bit age (0 = most recently used).
REQ-019 SHALL use the FSM states IDLE, WRITEBACK, REFILL, RESPOND; cpu_req_ready = 1 only in IDLE when not in reset.
REQ-020 SHALL treat a request as accepted when cpu_req_valid and cpu_req_ready are both high, registering addr, we and wdata.
REQ-021 SHALL, on a hit (valid and tag match), complete in IDLE with cpu_resp_valid high the cycle after acceptance (latency 1); a store writes the word and sets dirty.
REQ-022 SHALL, on a miss, choose the victim as the lowest-index invalid way, else the way with age WAYS-1.
REQ-023 SHALL go to WRITEBACK if the victim is valid and dirty, else to REFILL.
REQ-024 SHALL, in WRITEBACK, issue LINE_WORDS write beats (mem_req_we = 1) at victim tag/index, word 0 upward; each beat advances only on mem_req_valid and mem_req_ready.
REQ-025 SHALL, in REFILL, issue LINE_WORDS read beats, word 0 upward, then fill words in order on each mem_resp_valid.
REQ-026 SHALL keep outstanding reads ≤ LINE_WORDS and ignore mem_resp_valid outside REFILL.
REQ-027 SHALL, after the last refill word, set valid and the new tag, clear dirty, and enter RESPOND.
REQ-028 SHALL, in RESPOND, replay the request as a hit (write-allocate for stores), pulse cpu_resp_valid, and return to IDLE.
REQ-029 SHALL, on each completed access, set the accessed way's age to 0 and increment ages lower than its previous age (saturating at WAYS-1); other sets unchanged.
REQ-030 SHALL hold mem_req_addr, mem_req_we and mem_req_wdata stable while mem_req_valid = 1 and mem_req_ready = 0.
REQ-031 SHALL treat wrap-around in the word counter (LINE_WORDS-1 to 0) as end of burst.

Reset
REQ-032 SHALL, while reset is high, clear all valid, dirty and age bits, set the FSM to IDLE, and drive cpu_req_ready, cpu_resp_valid, mem_req_valid and mem_req_we to 0 and rdata to 0.
REQ-033 SHALL abandon any writeback or refill when reset asserts mid-burst; late mem_resp_valid after reset is ignored.
REQ-034 SHALL leave data and tag arrays unreset.

Configuration
REQ-035 SHALL, with L1_DCACHE_STATS_EN defined, add outputs hit_count and miss_count (32 bits each, reset 0, +1 per completed hit or miss, wrapping at 2^32).
REQ-036 SHALL, without L1_DCACHE_STATS_EN, omit those ports and counters, with no other behaviour change.

Verification
REQ-037 SHALL check a cold load: load 0x0000_1000 after reset → 4 read beats 0x1000..0x100C, refill, then resp with the beat-0 value; the repeat load hits at latency 1.
REQ-038 SHALL check a store hit: store 0xDEADBEEF to 0x1004 after the refill → resp next cycle; load 0x1004 returns 0xDEADBEEF.
REQ-039 SHALL check LRU eviction: fill set 0 with 5 distinct tags (default parameters) → the 5th evicts the 1st tag; dirty 0x1004 line is written back as 4 beats before the refill.
REQ-040 SHALL check backpressure: mem_req_ready low 3 cycles mid-WRITEBACK → addr and wdata held; the burst completes unchanged.
REQ-041 SHALL check reset mid-REFILL: reset after beat 2 → IDLE, line invalid, stale responses ignored, the next load refetches.
REQ-042 SHALL check stats: with L1_DCACHE_STATS_EN, the REQ-037 sequence gives hit_count = 1 and miss_count = 1.
